// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage:
// opcodes, the NOP word and the fetch FSM encoding.
package fetch_stage_pkg;

    localparam logic [5:0] OP_JMP = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] FS_FETCH   = 2'd0;
    localparam logic [1:0] FS_HOLD    = 2'd1;
    localparam logic [1:0] FS_DISCARD = 2'd2;

    // J-type target: upper nibble of the delay-free PC+4 plus the word index
    function automatic logic [31:0] jump_target(
        input logic [31:0] pc4,
        input logic [31:0] instr
    );
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and a valid bit,
// with write-enable and a flush that turns the load into a bubble.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        flush,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc4,
    input  logic        next_valid,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (we) begin
            instr <= flush ? NOP_INSTR : next_instr;
            pc4   <= next_pc4;
            valid <= flush ? 1'b0 : next_valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, one-word stall buffer, imem handshake FSM
// and the IF/ID register, steered by decode's stall and redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic        cu_jump,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] if_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    import fetch_stage_pkg::*;

    logic [1:0]  state;
    logic        buf_full;
    logic [31:0] buf_instr;

    logic        st_fetch;
    logic        st_hold;
    logic        st_discard;
    logic        fetch_done;
    logic        drop_done;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] if_pc4;
    logic        if_valid;
    logic        unused_lsb;

    assign st_fetch   = (state == FS_FETCH);
    assign st_hold    = (state == FS_HOLD);
    assign st_discard = (state == FS_DISCARD);

    assign imem_req  = rst && !buf_full && (st_fetch || st_discard);
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;

    assign fetch_done = imem_req && imem_ack && st_fetch;
    assign drop_done  = imem_req && imem_ack && st_discard;
    assign redirect   = cu_branch && !cu_wpcir;

    assign target = cu_jump ? jump_target(id_pc4, id_instr)
                            : {br_target[31:2], 2'b00};
    assign unused_lsb = ^br_target[1:0];

    // A buffered word came from pc-4, so its PC+4 is the current pc
    assign if_instr = buf_full   ? buf_instr :
                      fetch_done ? imem_rdata : NOP_INSTR;
    assign if_valid = buf_full || fetch_done;
    assign if_pc4   = buf_full ? pc : pc_plus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FS_FETCH;
            pc        <= RESET_PC;
            buf_full  <= 1'b0;
            buf_instr <= NOP_INSTR;
        end else if (redirect) begin
            pc       <= target;
            buf_full <= 1'b0;
            if (imem_req && !imem_ack)
                state <= FS_DISCARD;
            else
                state <= FS_FETCH;
        end else begin
            unique case (1'b1)
                st_fetch: begin
                    if (fetch_done) begin
                        pc <= pc_plus4;
                        if (cu_wpcir) begin
                            buf_instr <= imem_rdata;
                            buf_full  <= 1'b1;
                            state     <= FS_HOLD;
                        end
                    end
                end
                st_hold: begin
                    if (!cu_wpcir) begin
                        buf_full <= 1'b0;
                        state    <= FS_FETCH;
                    end
                end
                st_discard: begin
                    if (drop_done)
                        state <= FS_FETCH;
                end
                default: begin
                    state    <= FS_FETCH;
                    buf_full <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .we         (!cu_wpcir),
        .flush      (redirect),
        .next_instr (if_instr),
        .next_pc4   (if_pc4),
        .next_valid (if_valid),
        .instr      (id_instr),
        .pc4        (id_pc4),
        .valid      (id_valid)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined CPU.
- Consumes the decode-stage control outputs (stall/wpcir, branch, jump) and applies them: holds the PC, redirects it, or squashes the fetched instruction.
- Drives the instruction-memory request/acknowledge handshake.
- Supplies if_instr (the fetched, not-yet-decoded word, used for load-use detection) and id_instr (the instruction in decode) back to the control unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on bubble or squash.

Ports:
- clk, input, 1, pipeline clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- cu_wpcir, input, 1, load-use stall from the control unit; 1 = hold PC and IF/ID.
- cu_branch, input, 1, redirect request; this is the taken branch OR jump.
- cu_jump, input, 1, redirect is a jump; target is computed internally.
- br_target, input, 32, branch target (id_pc4 + sext(imm)<<2), computed by the datapath.
- imem_req, output, 1, fetch request.
- imem_addr, output, 32, fetch address; word aligned.
- imem_ack, input, 1, response valid this cycle.
- imem_rdata, input, 32, instruction word; valid when imem_ack=1.
- pc, output, 32, current fetch PC.
- if_instr, output, 32, instruction that will enter ID at the next unstalled edge; NOP_INSTR if none.
- id_instr, output, 32, IF/ID instruction register.
- id_pc4, output, 32, IF/ID PC+4 register.
- id_valid, output, 1, 1 = id_instr is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; id_instr=NOP_INSTR; id_pc4=0; id_valid=0.
  - Buffer empty; FSM=FETCH; imem_req=0 while rst=0.
- Handshake:
  - imem_req=1 whenever FSM is FETCH or DISCARD and the buffer is empty.
  - imem_addr=pc, held stable until the edge where imem_req&&imem_ack; the fetch completes at that edge.
  - Zero-wait-state acknowledge in the request cycle is legal.
- FSM states:
  - FETCH: request outstanding.
    - If ack, no redirect, and ID accepts (cu_wpcir=0): word goes directly to IF/ID and pc<=pc+4.
    - If ack and cu_wpcir=1: word goes to buffer, pc<=pc+4, state->HOLD.
  - HOLD: buffer full, imem_req=0. When cu_wpcir=0, buffer moves to IF/ID, buffer clears, state->FETCH.
  - DISCARD: entered when a redirect occurs while a fetch is outstanding without ack. The response for the old address is dropped; pc already holds the target. On that ack the state goes to FETCH and a new request issues the next cycle.
- if_instr: buffer if full; else imem_rdata if imem_ack in FETCH; else NOP_INSTR.
- IF/ID update at each edge with cu_wpcir=0:
  - Loads if_instr, pc+4 of that word, and id_valid=1 if a real word, else NOP_INSTR with id_valid=0 (wait-state bubble).
  - With cu_wpcir=1: IF/ID holds and pc holds unless a fetch completes into the buffer.
- Redirect (cu_branch=1 and cu_wpcir=0):
  - pc<=target. target = {id_pc4[31:28], id_instr[25:0], 2'b00} if cu_jump, else br_target.
  - No delay slot: IF/ID loads NOP_INSTR, id_valid=0.
  - Buffer and any same-cycle acked word are discarded.
  - If a fetch is outstanding without ack, state->DISCARD.
- Simultaneous events:
  - cu_wpcir=1 dominates cu_branch; the redirect is ignored that cycle and is re-evaluated from the control unit next cycle.
  - Redirect during DISCARD: pc updates to the newest target, state stays DISCARD.
- Arithmetic: PC+4 wraps modulo 2^32; bits [1:0] of pc are always 0 and br_target[1:0] is ignored.
- Reset mid-fetch: an outstanding request is abandoned and a late imem_ack after reset release is ignored until imem_req is reasserted.

Decomposition:
- Add to macro.vh: OP_JMP, OP_BEQ, NOP_INSTR, and the FSM state encodings FS_FETCH, FS_HOLD, FS_DISCARD (2 bits).
- One sub-module: if_id_reg, holding id_instr, id_pc4 and id_valid, with write-enable and flush inputs. The PC, buffer and FSM stay in fetch_stage.

Test Plan:
- Reset, then zero-wait memory returning 32'h0000_0820 at 0x0 and 32'h2001_0005 at 0x4 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; id_instr 32'h0000_0820 with id_pc4=0x4, then 32'h2001_0005 with id_pc4=0x8.
- Ack delayed 2 cycles at pc=0x8 -> imem_addr held 0x8 for 3 cycles; id_valid=0 with NOP_INSTR for 2 cycles, then the word appears with id_pc4=0xC.
- cu_wpcir=1 for 2 cycles while a fetch acks -> pc advances once to 0x10 then holds; id_instr unchanged; buffered word enters ID on the first edge after cu_wpcir=0; imem_req=0 while in HOLD.
- cu_branch=1, br_target=0x40 at pc=0x14 -> next imem_addr=0x40; ID gets NOP_INSTR with id_valid=0; the word fetched from 0x14 never reaches ID.
- cu_jump=cu_branch=1 with id_instr=32'h0800_0010 and id_pc4=0x1000_0008 -> pc=0x1000_0040.
- Redirect to 0x80 while the fetch at 0x20 is unacked, then ack after 1 cycle -> that ack's word is dropped; next request has imem_addr=0x80.
- Assert rst=0 mid-wait -> pc=RESET_PC, imem_req=0 immediately; a stray ack is ignored.
